// File: rtl/ddp_link_rx_if.sv
// Link beat stream plus ddpPkt FIFO write port of the DDP link receiver.
// The slave modport is the receiver; the master modport is the beat source / FIFO side.
interface ddp_link_rx_if;
    logic [63:0]  linkData;
    logic         linkValid;
    logic         linkSop;
    logic         linkEop;
    logic [2:0]   linkBytes;
    logic         linkReady;
    logic         ddpPktFull;
    logic         ddpPktPush;
    logic [264:0] ddpPktDataIn;

    modport master (
        output linkData, linkValid, linkSop, linkEop, linkBytes, ddpPktFull,
        input  linkReady, ddpPktPush, ddpPktDataIn
    );

    modport slave (
        input  linkData, linkValid, linkSop, linkEop, linkBytes, ddpPktFull,
        output linkReady, ddpPktPush, ddpPktDataIn
    );
endinterface

// File: rtl/ddp_link_rx.sv
// Link-side DDP receiver: packs sop/eop-framed 64-bit beats into 265-bit packet words for the
// ddpPkt FIFO, closing malformed or oversized packets with an error-flagged eop word.
module ddp_link_rx #(
    parameter int MAX_WORDS = 64
) (
    input  logic          clock,
    input  logic          reset,
    ddp_link_rx_if.slave  bus,
    output logic [15:0]   rxPktCnt,
    output logic [15:0]   rxErrCnt
);
    localparam int CW = $clog2(MAX_WORDS + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, DROP} state_t;

    state_t         state;
    state_t         state_next;

    logic [255:0]   asm_data;
    logic [1:0]     lane;
    logic           asm_sop;
    logic [CW-1:0]  word_cnt;
    logic           asm_done;
    logic [2:0]     done_bytes;
    logic           out_valid;
    logic [264:0]   out_data;

    logic [255:0]   asm_data_n;
    logic [1:0]     lane_n;
    logic           asm_sop_n;
    logic [CW-1:0]  word_cnt_n;
    logic           asm_done_n;
    logic [2:0]     done_bytes_n;
    logic           emit;
    logic [264:0]   emit_word;
    logic           inc_pkt;
    logic           inc_err;

    logic           out_free;
    logic           accept;
    logic           at_limit;
    logic [63:0]    beat;
    logic [255:0]   merged;
    logic [4:0]     eop_vb;
    logic [4:0]     err_vb;
    logic [264:0]   err_word;

    assign out_free         = ~out_valid | ~bus.ddpPktFull;
    assign bus.linkReady    = out_free & ~asm_done;
    assign bus.ddpPktPush   = out_valid & ~bus.ddpPktFull;
    assign bus.ddpPktDataIn = out_data;
    assign accept           = bus.linkValid & bus.linkReady;
    assign at_limit         = (word_cnt == CW'(MAX_WORDS));
    assign eop_vb           = {lane, bus.linkBytes};
    assign err_vb           = (lane == 2'd0) ? 5'd0 : ({lane, 3'b000} - 5'd1);
    assign err_word         = {asm_sop, 1'b1, err_vb, 1'b1, 1'b0, asm_data};

    // Bytes past linkBytes in an eop beat are zeroed so unfilled word bytes stay 0.
    always_comb begin
        beat = bus.linkData;
        if (bus.linkEop) begin
            for (int b = 0; b < 8; b++) begin
                if (b > int'(bus.linkBytes)) beat[8*b +: 8] = 8'h00;
            end
        end
        merged = asm_data;
        merged[{lane, 6'd0} +: 64] = beat;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (accept) begin
            if (bus.linkSop) begin
                state_next = bus.linkEop ? IDLE : COLLECT;
            end else begin
                case (state)
                    IDLE:    state_next = bus.linkEop ? IDLE : DROP;
                    COLLECT: begin
                        if (at_limit)         state_next = bus.linkEop ? IDLE : DROP;
                        else if (bus.linkEop) state_next = IDLE;
                    end
                    DROP:    if (bus.linkEop) state_next = IDLE;
                    default: state_next = IDLE;
                endcase
            end
        end
    end

    // A sop+eop beat arriving mid-packet needs two words (error close + the new packet); the
    // second is parked in asm with asm_done set and linkReady held low until out is free.
    always_comb begin
        asm_data_n   = asm_data;
        lane_n       = lane;
        asm_sop_n    = asm_sop;
        word_cnt_n   = word_cnt;
        asm_done_n   = asm_done;
        done_bytes_n = done_bytes;
        emit         = 1'b0;
        emit_word    = '0;
        inc_pkt      = 1'b0;
        inc_err      = 1'b0;
        if (asm_done) begin
            if (out_free) begin
                emit       = 1'b1;
                emit_word  = {2'b11, 2'b00, done_bytes, 2'b00, asm_data};
                inc_pkt    = 1'b1;
                asm_done_n = 1'b0;
                asm_data_n = '0;
                asm_sop_n  = 1'b0;
                lane_n     = 2'd0;
            end
        end else if (accept) begin
            if (bus.linkSop) begin
                if (state == COLLECT) begin
                    emit      = 1'b1;
                    emit_word = err_word;
                    inc_err   = 1'b1;
                end
                word_cnt_n = '0;
                if (bus.linkEop && state == COLLECT) begin
                    asm_done_n   = 1'b1;
                    done_bytes_n = bus.linkBytes;
                    asm_data_n   = {192'd0, beat};
                    asm_sop_n    = 1'b1;
                    lane_n       = 2'd0;
                end else if (bus.linkEop) begin
                    emit       = 1'b1;
                    emit_word  = {2'b11, 2'b00, bus.linkBytes, 2'b00, 192'd0, beat};
                    inc_pkt    = 1'b1;
                    asm_data_n = '0;
                    asm_sop_n  = 1'b0;
                    lane_n     = 2'd0;
                end else begin
                    asm_data_n = {192'd0, beat};
                    asm_sop_n  = 1'b1;
                    lane_n     = 2'd1;
                end
            end else begin
                case (state)
                    IDLE:    inc_err = 1'b1;
                    COLLECT: begin
                        if (at_limit) begin
                            emit       = 1'b1;
                            emit_word  = err_word;
                            inc_err    = 1'b1;
                            asm_data_n = '0;
                            asm_sop_n  = 1'b0;
                            lane_n     = 2'd0;
                        end else if (bus.linkEop) begin
                            emit       = 1'b1;
                            emit_word  = {asm_sop, 1'b1, eop_vb, 2'b00, merged};
                            inc_pkt    = 1'b1;
                            asm_data_n = '0;
                            asm_sop_n  = 1'b0;
                            lane_n     = 2'd0;
                        end else if (lane == 2'd3) begin
                            emit       = 1'b1;
                            emit_word  = {asm_sop, 1'b0, 5'd31, 2'b00, merged};
                            asm_data_n = '0;
                            asm_sop_n  = 1'b0;
                            lane_n     = 2'd0;
                            word_cnt_n = word_cnt + CW'(1);
                        end else begin
                            asm_data_n = merged;
                            lane_n     = lane + 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            asm_data   <= '0;
            lane       <= 2'd0;
            asm_sop    <= 1'b0;
            word_cnt   <= '0;
            asm_done   <= 1'b0;
            done_bytes <= 3'd0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            rxPktCnt   <= 16'd0;
            rxErrCnt   <= 16'd0;
        end else begin
            asm_data   <= asm_data_n;
            lane       <= lane_n;
            asm_sop    <= asm_sop_n;
            word_cnt   <= word_cnt_n;
            asm_done   <= asm_done_n;
            done_bytes <= done_bytes_n;
            if (emit) begin
                out_valid <= 1'b1;
                out_data  <= emit_word;
            end else if (bus.ddpPktPush) begin
                out_valid <= 1'b0;
            end
            if (inc_pkt && rxPktCnt != 16'hFFFF) rxPktCnt <= rxPktCnt + 16'd1;
            if (inc_err && rxErrCnt != 16'hFFFF) rxErrCnt <= rxErrCnt + 16'd1;
        end
    end
endmodule
